mac_row: RTL and testbench
==========================

Name: mac_row

Overview:
- One row of a weight-stationary systolic MAC array: `col` identical MAC tiles chained west-to-east.
- Weights are loaded serially from the west edge and stay resident in their tiles. Activations then stream west-to-east.
- Each tile adds its product to a north partial sum and drives the result south.
- Stacked vertically to form the array core of the distance/MAC engine.

Parameters:
- bw, 4, activation/weight width.
- psum_bw, 16, partial-sum width per column.
- col, 8, number of tiles in the row.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- out_s  output  psum_bw*col  south partial sums; tile k occupies bits [psum_bw*(k+1)-1 : psum_bw*k]; tile 0 is westmost.
- in_w  input  bw  west activation/weight input, feeds tile 0.
- in_n  input  psum_bw*col  north partial sums, same packing as out_s.
- valid  output  col  valid[k] = execute flag held in tile k.
- inst_w  input  3  instruction: bit0 = kernel load, bit1 = execute, bit2 = reserved (pipelined, no effect).

Behaviour:
- Tile k gets in_w and inst from tile k-1 (tile 0 from the row inputs). Its out_e/inst_e feed tile k+1; the last tile's east outputs are left unconnected.
- Per-tile registers:
  - a_q: bw bits.
  - b_q: bw bits, weight.
  - c_q: psum_bw bits.
  - inst_q: 3 bits.
  - load_ready_q: 1 bit.
- Reset (reset=0, async): a_q=b_q=c_q=0, inst_q=0, load_ready_q=1. Hence valid=0 and out_s=0.
- Every rising edge, out of reset:
  - a_q <= in_w when inst_w[0] or inst_w[1] is set; otherwise a_q holds.
  - If inst_w[0] and load_ready_q: b_q <= in_w and load_ready_q <= 0. This is a one-shot capture; later weights pass east.
  - inst_q[0] <= inst_w[0] only when load_ready_q is 0 before the edge; otherwise inst_q[0] holds.
  - inst_q[1] <= inst_w[1] and inst_q[2] <= inst_w[2] unconditionally.
  - c_q <= in_n slice.
- Outputs per tile:
  - out_e = a_q; inst_e = inst_q; valid = inst_q[1].
  - out_s = signed({1'b0,a_q}) * signed(b_q) + signed(c_q), computed combinationally.
  - Activation is unsigned; weight is two's-complement. The result is truncated/sign-extended to psum_bw.
- Loading:
  - Present W0..W(col-1) on in_w with inst_w=001 for col consecutive cycles.
  - Tile k captures Wk. Tile 0 captures on the first edge; tile k captures on edge 2k+1 counted from the first load edge.
  - Load must precede execute with no other ordering constraint. Inputs are held for at least 2*col cycles.
- Execute:
  - Activation x presented with inst_w=010 reaches tile k k cycles after tile 0.
  - valid[k] rises one edge after the instruction reaches the tile and lasts as many cycles as inst_w[1] was held.
- inst_w=000: a_q holds, valid deasserts in a wavefront from west to east.
- Overlapping load and execute (inst_w=011): both actions apply independently per the rules above.
- Reset mid-operation: all state clears and load_ready_q returns to 1, so weights must be reloaded.
- Weights cannot be changed without reset.

Decomposition:
- No shared package is required. If one is used, it holds only the inst bit indices (LOAD=0, EXEC=1, RSVD=2).
- One sub-module: mac_tile. It holds the registers above and instantiates the multiply-add.
- mac_row is a generate loop of `col` mac_tile instances plus wiring.

Test Plan:
- Reset: hold reset=0 for 2 cycles with random inputs -> valid=0, out_s=0. Release reset with inst_w=000 -> outputs stay 0.
- Load: inst_w=001 with in_w=F,E,D,C,B,A,9,8 over 8 cycles, then idle 16 cycles -> tile k b_q = F-k (tile 0 = -1, tile 7 = -8), valid stays 0.
- Execute after the load above, in_n=0: one cycle of inst_w=010 with in_w=1, then 000 with in_w=2..9 -> valid[k] high for exactly one cycle, k cycles after valid[0]. In that cycle, out_s slice k = -(k+1), e.g. tile 0 = 0xFFFF, tile 7 = 0xFFF8.
- Psum path: same weights, in_n slices all 0x0010, execute with activation 3 -> tile 0 = 0x000D, tile 1 = 0x000A.
- Signed range: weight 8 (-8) and activation F (15) in tile 0 -> out_s slice 0 = 0xFF88 (-120).
- Mid-execute reset: pulse reset low while valid[3] is high -> all valid=0 and out_s=0 at once. A new execute without reloading yields 0 products (b_q=0).

Source files
------------

// File: rtl/mac_row_pkg.sv
// mac_row_pkg: shared instruction-bit indices for the MAC row and its tiles.
//   InstLoad - kernel (weight) load request
//   InstExec - execute request, surfaces as the tile valid flag
//   InstRsvd - reserved, carried east through the pipeline with no effect
package mac_row_pkg;

  localparam int unsigned InstLoad = 0;
  localparam int unsigned InstExec = 1;
  localparam int unsigned InstRsvd = 2;

endpackage

// File: rtl/mac_row_tile.sv
// mac_tile: one weight-stationary MAC tile.
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset
//   in_w   - activation/weight from the west neighbour
//   out_e  - registered activation/weight to the east neighbour
//   inst_w - instruction from the west neighbour
//   inst_e - registered instruction to the east neighbour
//   in_n   - north partial sum
//   out_s  - south partial sum: unsigned act * signed weight + registered north psum
//   valid  - registered execute flag
module mac_tile
  import mac_row_pkg::*;
#(
  parameter int unsigned bw      = 4,
  parameter int unsigned psum_bw = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [bw-1:0]      in_w,
  output logic [bw-1:0]      out_e,
  input  logic [2:0]         inst_w,
  output logic [2:0]         inst_e,
  input  logic [psum_bw-1:0] in_n,
  output logic [psum_bw-1:0] out_s,
  output logic               valid
);

  logic [bw-1:0]      r_a;
  logic [bw-1:0]      r_b;
  logic [psum_bw-1:0] r_c;
  logic [2:0]         r_inst;
  logic               r_load_ready;

  logic [psum_bw-1:0] w_a_ext;
  logic [psum_bw-1:0] w_b_ext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a          <= '0;
      r_b          <= '0;
      r_c          <= '0;
      r_inst       <= '0;
      r_load_ready <= 1'b1;
    end else begin
      if (inst_w[InstLoad] || inst_w[InstExec]) begin
        r_a <= in_w;
      end
      // One-shot weight capture; every later weight only passes east.
      if (inst_w[InstLoad] && r_load_ready) begin
        r_b          <= in_w;
        r_load_ready <= 1'b0;
      end
      // The load flag is forwarded only once this tile holds its own weight,
      // so the east neighbour never sees the weight this tile consumed.
      if (!r_load_ready) begin
        r_inst[InstLoad] <= inst_w[InstLoad];
      end
      r_inst[InstExec] <= inst_w[InstExec];
      r_inst[InstRsvd] <= inst_w[InstRsvd];
      r_c              <= in_n;
    end
  end

  // Zero-extend the activation and sign-extend the weight to psum_bw; the low
  // psum_bw bits of the product are then the correctly truncated signed result.
  always_comb begin
    w_a_ext = {{(psum_bw - bw){1'b0}}, r_a};
    w_b_ext = {{(psum_bw - bw){r_b[bw-1]}}, r_b};
    out_s   = w_a_ext * w_b_ext + r_c;
  end

  assign out_e  = r_a;
  assign inst_e = r_inst;
  assign valid  = r_inst[InstExec];

endmodule

// File: rtl/mac_row.sv
// mac_row: one row of a weight-stationary systolic MAC array, col tiles chained
// west to east.
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset
//   out_s  - south partial sums, tile k at [psum_bw*(k+1)-1 : psum_bw*k]
//   in_w   - west activation/weight input into tile 0
//   in_n   - north partial sums, same packing as out_s
//   valid  - valid[k] is the execute flag held in tile k
//   inst_w - instruction: bit0 load, bit1 execute, bit2 reserved
module mac_row
  import mac_row_pkg::*;
#(
  parameter int unsigned bw      = 4,
  parameter int unsigned psum_bw = 16,
  parameter int unsigned col     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [psum_bw*col-1:0] out_s,
  input  logic [bw-1:0]          in_w,
  input  logic [psum_bw*col-1:0] in_n,
  output logic [col-1:0]         valid,
  input  logic [2:0]             inst_w
);

  localparam int unsigned InstBits = InstRsvd + 1;

  logic [col:0][bw-1:0]       w_act;
  logic [col:0][InstBits-1:0] w_inst;
  // East outputs of the last tile have no consumer.
  logic [bw+InstBits-1:0]     w_unused_east;

  assign w_act[0]      = in_w;
  assign w_inst[0]     = inst_w;
  assign w_unused_east = {w_act[col], w_inst[col]};

  for (genvar k = 0; k < col; k++) begin : g_tile
    mac_tile #(
      .bw     (bw),
      .psum_bw(psum_bw)
    ) u_tile (
      .clk   (clk),
      .reset (reset),
      .in_w  (w_act[k]),
      .out_e (w_act[k+1]),
      .inst_w(w_inst[k]),
      .inst_e(w_inst[k+1]),
      .in_n  (in_n[psum_bw*k +: psum_bw]),
      .out_s (out_s[psum_bw*k +: psum_bw]),
      .valid (valid[k])
    );
  end

endmodule

// File: tb/tb_mac_row.sv
module tb_mac_row;

  logic         clk;
  logic         reset;
  logic [127:0] out_s;
  logic [3:0]   in_w;
  logic [127:0] in_n;
  logic [7:0]   valid;
  logic [2:0]   inst_w;

  int total;
  int bad;

  logic [15:0] exp_neg  [8];
  logic [15:0] exp_psum [8];

  mac_row #(
    .bw     (4),
    .psum_bw(16),
    .col    (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .out_s (out_s),
    .in_w  (in_w),
    .in_n  (in_n),
    .valid (valid),
    .inst_w(inst_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] sl(input int k);
    return out_s[16*k +: 16];
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    // tile k weight F-k times activation 1
    exp_neg  = '{16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC,
                 16'hFFFB, 16'hFFFA, 16'hFFF9, 16'hFFF8};
    // 3 * (-(k+1)) + 16
    exp_psum = '{16'h000D, 16'h000A, 16'h0007, 16'h0004,
                 16'h0001, 16'hFFFE, 16'hFFFB, 16'hFFF8};

    // Reset with random inputs
    reset  = 1'b0;
    in_w   = 4'($urandom);
    inst_w = 3'($urandom);
    in_n   = {$urandom, $urandom, $urandom, $urandom};
    step();
    in_w   = 4'($urandom);
    inst_w = 3'($urandom);
    in_n   = {$urandom, $urandom, $urandom, $urandom};
    step();
    chk("rst_valid", 128'(valid), 128'h0);
    chk("rst_out_s", out_s, 128'h0);

    in_w   = 4'h0;
    inst_w = 3'b000;
    in_n   = '0;
    reset  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("idle_valid%0d", i), 128'(valid), 128'h0);
      chk($sformatf("idle_out_s%0d", i), out_s, 128'h0);
    end

    // Load weights F..8
    for (int i = 0; i < 8; i++) begin
      in_w   = 4'(15 - i);
      inst_w = 3'b001;
      step();
      chk($sformatf("load_valid%0d", i), 128'(valid), 128'h0);
    end
    inst_w = 3'b000;
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("settle_valid%0d", i), 128'(valid), 128'h0);
    end

    // Execute activation 1, in_n = 0
    in_w   = 4'h1;
    inst_w = 3'b010;
    step();
    chk("exec_valid0", 128'(valid), 128'h01);
    chk("exec_s0", 128'(sl(0)), 128'(exp_neg[0]));
    inst_w = 3'b000;
    for (int k = 1; k < 8; k++) begin
      in_w = 4'(k + 1);
      step();
      chk($sformatf("exec_valid%0d", k), 128'(valid), 128'(8'h01 << k));
      chk($sformatf("exec_s%0d", k), 128'(sl(k)), 128'(exp_neg[k]));
    end
    step();
    chk("exec_valid_done", 128'(valid), 128'h0);

    // Psum path: in_n = 0x0010 everywhere, activation 3
    in_n = {8{16'h0010}};
    step();
    in_w   = 4'h3;
    inst_w = 3'b010;
    step();
    chk("psum_valid0", 128'(valid), 128'h01);
    chk("psum_s0", 128'(sl(0)), 128'(exp_psum[0]));
    inst_w = 3'b000;
    in_w   = 4'h0;
    for (int k = 1; k < 8; k++) begin
      step();
      chk($sformatf("psum_valid%0d", k), 128'(valid), 128'(8'h01 << k));
      chk($sformatf("psum_s%0d", k), 128'(sl(k)), 128'(exp_psum[k]));
    end
    step();

    // Signed range: reload every tile with weight 8 (-8), activation F
    reset = 1'b0;
    #2;
    chk("rst2_valid", 128'(valid), 128'h0);
    chk("rst2_out_s", out_s, 128'h0);
    reset = 1'b1;
    in_n  = '0;
    for (int i = 0; i < 8; i++) begin
      in_w   = 4'h8;
      inst_w = 3'b001;
      step();
    end
    inst_w = 3'b000;
    for (int i = 0; i < 16; i++) step();
    in_w   = 4'hF;
    inst_w = 3'b010;
    step();
    chk("range_valid0", 128'(valid), 128'h01);
    chk("range_s0", 128'(sl(0)), 128'hFF88);
    inst_w = 3'b000;
    for (int k = 1; k < 8; k++) begin
      step();
      chk($sformatf("range_s%0d", k), 128'(sl(k)), 128'hFF88);
    end
    step();

    // Mid-execute reset while valid[3] is high
    in_n = {8{16'h0010}};
    step();
    in_w   = 4'hF;
    inst_w = 3'b010;
    step();
    inst_w = 3'b000;
    for (int i = 0; i < 3; i++) step();
    chk("mid_valid3", 128'(valid), 128'h08);
    chk("mid_s3", 128'(sl(3)), 128'hFF98);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(valid), 128'h0);
    chk("mid_rst_out_s", out_s, 128'h0);
    #1;
    reset = 1'b1;

    // Execute without reload: weights are gone, only the north psum passes
    in_w   = 4'hF;
    inst_w = 3'b010;
    step();
    chk("noload_valid0", 128'(valid), 128'h01);
    chk("noload_s0", 128'(sl(0)), 128'h0010);
    inst_w = 3'b000;
    for (int k = 1; k < 8; k++) begin
      step();
      chk($sformatf("noload_valid%0d", k), 128'(valid), 128'(8'h01 << k));
      chk($sformatf("noload_s%0d", k), 128'(sl(k)), 128'h0010);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
